// File: rtl/ahb2_pkg.sv
// -----------------------------------------------------------------------------
// ahb2_pkg
// Shared AHB2 encodings and helpers for the ahb2_slv_sram slave.
//   htrans_e : HTRANS transfer types
//   hsize_e  : supported HSIZE values (byte/half/word)
//   hresp_e  : HRESP responses (only OKAY and ERROR are ever driven)
//   state_e  : data-phase FSM states of the SRAM slave
//   byte_en  : little-endian byte lane enables from size and address[1:0]
// -----------------------------------------------------------------------------
package ahb2_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    // Lane 0 is the least significant byte (little-endian bus).
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        if (size == SIZE_BYTE) begin
            be = 4'b0001 << lo;
        end else if (size == SIZE_HALF) begin
            be = lo[1] ? 4'b1100 : 4'b0011;
        end else if (size == SIZE_WORD) begin
            be = 4'b1111;
        end
        return be;
    endfunction

endpackage

// File: rtl/ahb2_slv_sram_if.sv
// -----------------------------------------------------------------------------
// ahb2_slv_sram_if
// AHB2 slave-side bus bundle.
//   master modport : drives select/address/control/write data and bus HREADY
//   slave modport  : drives hready_o, hresp_o and hrdata_o
// Signals:
//   hsel_i, haddr_i[31:0], htrans_i[1:0], hwrite_i, hsize_i[2:0],
//   hburst_i[2:0], hwdata_i[31:0], hready_i  -> into the slave
//   hready_o, hresp_o[1:0], hrdata_o[31:0]   <- from the slave
// -----------------------------------------------------------------------------
interface ahb2_slv_sram_if;

    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [2:0]  hburst_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic        hready_o;
    logic [1:0]  hresp_o;
    logic [31:0] hrdata_o;

    modport master (
        output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hwdata_i, hready_i,
        input  hready_o, hresp_o, hrdata_o
    );

    modport slave (
        input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hwdata_i, hready_i,
        output hready_o, hresp_o, hrdata_o
    );

endinterface

// File: rtl/ahb2_slv_sram_array.sv
// -----------------------------------------------------------------------------
// ahb2_slv_sram_array
// DEPTH x 32-bit storage with per-byte write enables, one write port and one
// asynchronous read port. Contents are not reset.
//   clk    : write clock
//   we     : byte write enables (bit n writes wdata[8n+7:8n])
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module ahb2_slv_sram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Asynchronous read lets a read data phase directly after a write data
    // phase to the same word see the merged bytes without a bypass path.
    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb2_slv_sram.sv
// -----------------------------------------------------------------------------
// ahb2_slv_sram
// AHB2 slave in front of a DEPTH x 32-bit SRAM with optional data-phase wait
// states and a two-cycle ERROR response for unsupported sizes, misaligned or
// out-of-range addresses.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ahb2_slv_sram_if.slave (select, address, control, write data,
//           bus HREADY in; hready_o, hresp_o, hrdata_o out)
// Parameters:
//   DEPTH       : number of 32-bit words
//   WAIT_STATES : wait cycles inserted per OKAY transfer (0..7)
//   BASE_ADDR   : byte address of word 0
// -----------------------------------------------------------------------------
module ahb2_slv_sram
    import ahb2_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    ahb2_slv_sram_if.slave  bus
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [2:0]  WS      = 3'(WAIT_STATES);

    state_e        state;
    logic          hready_q;
    logic [1:0]    hresp_q;
    logic [2:0]    wait_cnt;

    logic [AW-1:0] idx_p1;
    logic [1:0]    lo_p1;
    logic [2:0]    size_p1;
    logic          write_p1;

    logic [31:0]   addr_off;
    logic          accept;
    logic          xfer_bad;
    logic [3:0]    wr_be;
    logic [31:0]   rd_word;
    logic          unused_ok;

    function automatic logic addr_err(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        logic        bad;
        off = addr - BASE_ADDR;
        bad = 1'b0;
        if (size > SIZE_WORD)                        bad = 1'b1;
        if (size == SIZE_HALF && addr[0])            bad = 1'b1;
        if (size == SIZE_WORD && addr[1:0] != 2'b00) bad = 1'b1;
        if (addr < BASE_ADDR)                        bad = 1'b1;
        if ((off >> 2) >= DEPTH_W)                   bad = 1'b1;
        return bad;
    endfunction

    assign addr_off = bus.haddr_i - BASE_ADDR;
    assign accept   = bus.hsel_i & bus.hready_i &
                      ((bus.htrans_i == TRANS_NONSEQ) | (bus.htrans_i == TRANS_SEQ));
    assign xfer_bad = addr_err(bus.haddr_i, bus.hsize_i);

    // hburst_i is informational only; each beat stands on its own.
    assign unused_ok = ^{bus.hburst_i, addr_off};

    // ---- address phase -> data phase ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
            wait_cnt <= 3'd0;
            idx_p1   <= '0;
            lo_p1    <= 2'd0;
            size_p1  <= 3'd0;
            write_p1 <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state    <= ST_DATA;
                        hready_q <= 1'b1;
                        hresp_q  <= RESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 all complete this cycle, so each
                    // may take the next address phase without a bubble.
                    if (accept) begin
                        idx_p1  <= addr_off[AW+1:2];
                        lo_p1   <= bus.haddr_i[1:0];
                        size_p1 <= bus.hsize_i;
                        if (xfer_bad) begin
                            state    <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= RESP_ERROR;
                            write_p1 <= 1'b0;
                        end else if (WS != 3'd0) begin
                            state    <= ST_WAIT;
                            hready_q <= 1'b0;
                            hresp_q  <= RESP_OKAY;
                            wait_cnt <= WS - 3'd1;
                            write_p1 <= bus.hwrite_i;
                        end else begin
                            state    <= ST_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= RESP_OKAY;
                            write_p1 <= bus.hwrite_i;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= RESP_OKAY;
                        write_p1 <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ---- data phase: storage access ----
    assign wr_be = (state == ST_DATA && write_p1) ? byte_en(size_p1, lo_p1) : 4'b0000;

    ahb2_slv_sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (wr_be),
        .waddr (idx_p1),
        .wdata (bus.hwdata_i),
        .raddr (idx_p1),
        .rdata (rd_word)
    );

    assign bus.hready_o = hready_q;
    assign bus.hresp_o  = hresp_q;
    assign bus.hrdata_o = (state == ST_DATA && !write_p1) ? rd_word : 32'd0;

endmodule

// File: doc/ahb2_slv_sram.md
AHB2_SLV_SRAM -- requirements
Module: ahb2_slv_sram

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_STATES, default 0, the data-phase wait cycles inserted per OKAY transfer (range 0..7).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 hsel_i  input  1  slave select.
REQ-007 haddr_i  input  32  byte address, address phase.
REQ-008 htrans_i  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 hwrite_i  input  1  1 = write.
REQ-010 hsize_i  input  3  0 = byte, 1 = half, 2 = word; 3..7 = unsupported.
REQ-011 hburst_i  input  3  burst type; informational only, ignored.
REQ-012 hwdata_i  input  32  write data, data phase.
REQ-013 hready_i  input  1  bus-level HREADY (previous transfer complete).
REQ-014 hready_o  output  1  slave ready.
REQ-015 hresp_o  output  2  OKAY=0, ERROR=1; RETRY/SPLIT never driven.
REQ-016 hrdata_o  output  32  read data, valid while hready_o=1 in a read data phase.

Function
REQ-017 Transfer accepted SHALL be hsel_i & hready_i & htrans_i[1]; on acceptance latch haddr_i, hwrite_i and hsize_i into data-phase registers.
REQ-018 IDLE/BUSY or unselected cycles SHALL produce a zero-wait OKAY response (hready_o=1, hresp_o=OKAY) and change no state beyond clearing the pending transfer.
REQ-019 FSM states: IDLE, DATA, WAIT, ERR1, ERR2; acceptance moves to WAIT when WAIT_STATES>0, else to DATA; WAIT counts down WAIT_STATES cycles with hready_o=0, hresp_o=OKAY, then DATA.
REQ-020 In DATA, hready_o SHALL be 1 and hresp_o OKAY; a new transfer accepted in the same cycle re-enters WAIT/DATA (back-to-back pipelining, no bubble when WAIT_STATES=0).
REQ-021 Error cases: hsize_i>2, misalignment (half with haddr[0]=1, word with haddr[1:0]!=0), or word index (haddr-BASE_ADDR)>>2 >= DEPTH, or haddr < BASE_ADDR.
REQ-022 An erroneous transfer SHALL go to ERR1 (hready_o=0, hresp_o=ERROR), then ERR2 (hready_o=1, hresp_o=ERROR); no storage write; hrdata_o=0.
REQ-023 A transfer accepted during ERR2 SHALL be processed normally (ERR2 acts as DATA for pipelining).
REQ-024 A write SHALL commit hwdata_i in the DATA cycle only, using little-endian byte enables from latched hsize and haddr[1:0]; unenabled bytes unchanged.
REQ-025 A read SHALL return the full addressed 32-bit word on hrdata_o in DATA (narrow reads return all lanes); hrdata_o SHALL be 0 outside read DATA cycles.
REQ-026 Read-after-write: a read whose DATA cycle follows a write DATA cycle to the same word SHALL return the merged (just-written) bytes.
REQ-027 hburst_i and burst boundaries SHALL not affect behaviour; each beat is handled as an independent transfer.

Reset
REQ-028 While rst_n=0: state IDLE, hready_o=1, hresp_o=OKAY, hrdata_o=0, wait counter 0, data-phase registers cleared.
REQ-029 Reset asserted mid-transfer SHALL abandon it without writing storage; storage contents are not reset and are undefined until written.

Structure
REQ-030 HTRANS, HSIZE and HRESP encodings SHALL be typedef enums in shared package ahb2_pkg.
REQ-031 Storage SHALL be a sub-module ahb2_slv_sram_array (DEPTH x 32, per-byte write enables, one read port, one write port).

Verification
REQ-032 WAIT_STATES=0: NONSEQ word write 0x10 = 0xDEADBEEF, then read 0x10 back-to-back -> hready_o never low, read returns 0xDEADBEEF, OKAY.
REQ-033 Byte write 0xAA to 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344.
REQ-034 WAIT_STATES=3: word read -> hready_o low exactly 3 cycles, then high with data, OKAY.
REQ-035 Word access to 0x02, hsize=3, and address BASE_ADDR+4*DEPTH -> each gives ERR1 (hready_o=0, ERROR), ERR2 (hready_o=1, ERROR), storage unchanged.
REQ-036 rst_n pulled low during a WAIT cycle of a write -> outputs at reset values immediately; a subsequent read shows the old word unchanged.
REQ-037 IDLE, BUSY, and hsel_i=0 cycles interleaved in a 4-beat INCR burst -> OKAY zero-wait on idle cycles, all four beats written correctly.
